// File: rtl/tx_arbiter.sv
// Round-robin arbiter granting one UART transmit byte at a time to either the
// manual-operation requester or the script executor. Each granted byte waits
// for tx_ready (or times out), then a fixed idle gap precedes the next grant.
module tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned GAP_CYCLES     = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_script_mode,
    input  logic       i_m_req,
    input  logic [7:0] i_m_bits,
    output logic       o_m_ack,
    input  logic       i_s_req,
    input  logic [7:0] i_s_bits,
    output logic       o_s_ack,
    input  logic       i_tx_ready,
    output logic [7:0] o_tx_bits,
    output logic       o_busy,
    output logic       o_owner,
    output logic       o_timeout_err,
    output logic       o_err_flag
);

    // Wait counter only ever reaches TIMEOUT_CYCLES-1; gap counter reaches GAP_CYCLES-1 <= 254.
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e        r_state, w_state_nxt;
    logic [TW-1:0] r_wait, w_wait_nxt;
    logic [7:0]    r_gap, w_gap_nxt;
    logic [7:0]    r_tx_bits, w_tx_bits_nxt;
    logic          r_owner, w_owner_nxt;
    logic          r_m_ack, w_m_ack_nxt;
    logic          r_s_ack, w_s_ack_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_timeout_err, w_timeout_err_nxt;
    logic          r_err_flag, w_err_flag_nxt;
    logic          w_winner;

    // Round-robin pick: on a tie the requester that did not own the last grant wins.
    always_comb begin
        if (i_m_req && i_s_req) begin
            w_winner = ~r_owner;
        end else begin
            w_winner = i_s_req;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_wait_nxt        = r_wait;
        w_gap_nxt         = r_gap;
        w_tx_bits_nxt     = r_tx_bits;
        w_owner_nxt       = r_owner;
        w_m_ack_nxt       = 1'b0;
        w_s_ack_nxt       = 1'b0;
        w_timeout_err_nxt = 1'b0;
        w_err_flag_nxt    = r_err_flag;
        unique case (r_state)
            StIdle: begin
                if (!i_script_mode && (i_m_req || i_s_req)) begin
                    w_state_nxt   = StGrant;
                    w_wait_nxt    = '0;
                    w_owner_nxt   = w_winner;
                    w_tx_bits_nxt = w_winner ? i_s_bits : i_m_bits;
                end
            end
            StGrant: begin
                if (i_tx_ready) begin
                    w_m_ack_nxt = ~r_owner;
                    w_s_ack_nxt = r_owner;
                    w_state_nxt = StGap;
                    w_gap_nxt   = '0;
                end else if (r_wait == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout_err_nxt = 1'b1;
                    w_err_flag_nxt    = 1'b1;
                    w_state_nxt       = StGap;
                    w_gap_nxt         = '0;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            StGap: begin
                if (r_gap == 8'(GAP_CYCLES - 1)) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
        w_busy_nxt = (w_state_nxt != StIdle);
    end

    // State and registered outputs; reset drops any transfer in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_wait        <= '0;
            r_gap         <= '0;
            r_tx_bits     <= 8'h00;
            r_owner       <= 1'b1;
            r_m_ack       <= 1'b0;
            r_s_ack       <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_err_flag    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait        <= w_wait_nxt;
            r_gap         <= w_gap_nxt;
            r_tx_bits     <= w_tx_bits_nxt;
            r_owner       <= w_owner_nxt;
            r_m_ack       <= w_m_ack_nxt;
            r_s_ack       <= w_s_ack_nxt;
            r_busy        <= w_busy_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_err_flag    <= w_err_flag_nxt;
        end
    end

    assign o_m_ack       = r_m_ack;
    assign o_s_ack       = r_s_ack;
    assign o_tx_bits     = r_tx_bits;
    assign o_busy        = r_busy;
    assign o_owner       = r_owner;
    assign o_timeout_err = r_timeout_err;
    assign o_err_flag    = r_err_flag;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_tx_arbiter;

    localparam int unsigned TO  = 16;
    localparam int unsigned GAP = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       script;
    logic       m_req, s_req, tx_ready;
    logic [7:0] m_bits, s_bits;
    logic       m_ack, s_ack, busy, owner, timeout_err, err_flag;
    logic [7:0] tx_bits;

    int n_cmp = 0;
    int n_mis = 0;
    int m_ack_seen = 0;

    // Reference model: a grant in progress, elapsed wait cycles, remaining gap cycles.
    bit         md_grant;
    int         md_elapsed;
    int         md_gap_left;
    bit         md_owner;
    logic [7:0] md_tx;
    bit         md_err;
    bit         exp_m_ack, exp_s_ack, exp_to, grant_evt;

    tx_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .GAP_CYCLES    (GAP)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_script_mode(script),
        .i_m_req      (m_req),
        .i_m_bits     (m_bits),
        .o_m_ack      (m_ack),
        .i_s_req      (s_req),
        .i_s_bits     (s_bits),
        .o_s_ack      (s_ack),
        .i_tx_ready   (tx_ready),
        .o_tx_bits    (tx_bits),
        .o_busy       (busy),
        .o_owner      (owner),
        .o_timeout_err(timeout_err),
        .o_err_flag   (err_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        md_grant    = 1'b0;
        md_elapsed  = 0;
        md_gap_left = 0;
        md_owner    = 1'b1;
        md_tx       = 8'h00;
        md_err      = 1'b0;
        exp_m_ack   = 1'b0;
        exp_s_ack   = 1'b0;
        exp_to      = 1'b0;
        grant_evt   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present before the edge.
    task automatic model_step();
        bit win;
        exp_m_ack = 1'b0;
        exp_s_ack = 1'b0;
        exp_to    = 1'b0;
        grant_evt = 1'b0;
        if (md_gap_left > 0) begin
            md_gap_left--;
        end else if (md_grant) begin
            if (tx_ready) begin
                if (md_owner) exp_s_ack = 1'b1;
                else exp_m_ack = 1'b1;
                md_grant    = 1'b0;
                md_gap_left = GAP;
            end else if (md_elapsed == int'(TO) - 1) begin
                exp_to      = 1'b1;
                md_err      = 1'b1;
                md_grant    = 1'b0;
                md_gap_left = GAP;
            end else begin
                md_elapsed++;
            end
        end else if (!script && (m_req || s_req)) begin
            win        = (m_req && s_req) ? !md_owner : s_req;
            md_owner   = win;
            md_tx      = win ? s_bits : m_bits;
            md_grant   = 1'b1;
            md_elapsed = 0;
            grant_evt  = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check("tx_bits", 32'(tx_bits), 32'(md_tx));
        check("owner", 32'(owner), 32'(md_owner));
        check("busy", 32'(busy), 32'(md_grant || (md_gap_left > 0)));
        check("m_ack", 32'(m_ack), 32'(exp_m_ack));
        check("s_ack", 32'(s_ack), 32'(exp_s_ack));
        check("timeout_err", 32'(timeout_err), 32'(exp_to));
        check("err_flag", 32'(err_flag), 32'(md_err));
        if (m_ack) m_ack_seen++;
    endtask

    // One clock: inputs already driven at the preceding falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        script   = 1'b0;
        m_req    = 1'b0;
        s_req    = 1'b0;
        tx_ready = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_reset();
        check_outputs();
        step();
        rst_n      = 1'b1;
        m_ack_seen = 0;
    endtask

    logic [7:0] bits_q[$];
    int         ack_q[$];
    logic [7:0] exp_seq[3];
    int         k;

    initial begin
        script   = 1'b0;
        m_req    = 1'b0;
        s_req    = 1'b0;
        tx_ready = 1'b0;
        m_bits   = 8'h00;
        s_bits   = 8'h00;
        rst_n    = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_tx_bits", 32'(tx_bits), 32'h00);
        check("reset_owner", 32'(owner), 32'h1);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_err_flag", 32'(err_flag), 32'h0);
        rst_n = 1'b1;

        // Single manual request, tx_ready 10 cycles after grant.
        do_reset();
        m_req  = 1'b1;
        m_bits = 8'h35;
        step();
        check("single_tx_bits", 32'(tx_bits), 32'h35);
        check("single_owner", 32'(owner), 32'h0);
        check("single_busy", 32'(busy), 32'h1);
        repeat (9) step();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        m_req    = 1'b0;
        check("single_ack", 32'(m_ack), 32'h1);
        repeat (GAP) step();
        check("single_idle", 32'(busy), 32'h0);
        step();
        check("single_ack_count", 32'(m_ack_seen), 32'h1);

        // Both requesting from reset: manual wins first, then alternation.
        do_reset();
        m_bits = 8'hA1;
        s_bits = 8'hB2;
        m_req  = 1'b1;
        s_req  = 1'b1;
        bits_q.delete();
        ack_q.delete();
        for (int c = 0; c < 300 && ack_q.size() < 3; c++) begin
            tx_ready = md_grant && (md_elapsed == 2);
            step();
            if (grant_evt) bits_q.push_back(tx_bits);
            if (m_ack) ack_q.push_back(0);
            if (s_ack) ack_q.push_back(1);
        end
        m_req    = 1'b0;
        s_req    = 1'b0;
        tx_ready = 1'b0;
        exp_seq  = '{8'hA1, 8'hB2, 8'hA1};
        check("rr_ack_count", 32'(ack_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("rr_bits", (i < bits_q.size()) ? 32'(bits_q[i]) : 32'hDEAD, 32'(exp_seq[i]));
            check("rr_ack_who", (i < ack_q.size()) ? 32'(ack_q[i]) : 32'hDEAD, 32'(i % 2));
        end
        repeat (GAP + 2) step();

        // script_mode blocks grants; release grants on the next edge.
        do_reset();
        script = 1'b1;
        m_req  = 1'b1;
        m_bits = 8'h5A;
        repeat (50) step();
        check("script_busy", 32'(busy), 32'h0);
        script = 1'b0;
        step();
        check("script_release", 32'(busy), 32'h1);
        check("script_release_bits", 32'(tx_bits), 32'h5A);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        m_req    = 1'b0;
        repeat (GAP + 1) step();

        // Timeout with no tx_ready.
        do_reset();
        m_req  = 1'b1;
        m_bits = 8'hC3;
        step();
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (timeout_err) begin
                k = c;
                break;
            end
        end
        m_req = 1'b0;
        check("timeout_cycle", 32'(k), 32'(TO));
        check("timeout_err_flag", 32'(err_flag), 32'h1);
        repeat (GAP) step();
        check("timeout_idle", 32'(busy), 32'h0);
        check("timeout_no_ack", 32'(m_ack_seen), 32'h0);

        // Reset asserted 5 cycles into a grant.
        do_reset();
        m_req  = 1'b1;
        m_bits = 8'h77;
        step();
        repeat (5) step();
        m_req = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_tx_bits", 32'(tx_bits), 32'h00);
        step();
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("midrst_no_ack", 32'(m_ack), 32'h0);

        // tx_ready in IDLE and GAP ignored; dropped req still acked.
        do_reset();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("idle_rdy_busy", 32'(busy), 32'h0);
        m_req  = 1'b1;
        m_bits = 8'h9E;
        step();
        m_req = 1'b0;
        repeat (3) step();
        tx_ready = 1'b1;
        step();
        check("drop_req_ack", 32'(m_ack), 32'h1);
        step();
        tx_ready = 1'b0;
        check("gap_rdy_ack", 32'(m_ack), 32'h0);
        check("gap_rdy_busy", 32'(busy), 32'h1);
        repeat (GAP) step();

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (exp_m_ack) begin
                m_req  = 1'($urandom % 2);
                m_bits = 8'($urandom);
            end else if (!m_req && ($urandom % 4 == 0)) begin
                m_req  = 1'b1;
                m_bits = 8'($urandom);
            end else if (m_req && ($urandom % 64 == 0)) begin
                m_req = 1'b0;
            end
            if (exp_s_ack) begin
                s_req  = 1'($urandom % 2);
                s_bits = 8'($urandom);
            end else if (!s_req && ($urandom % 4 == 0)) begin
                s_req  = 1'b1;
                s_bits = 8'($urandom);
            end else if (s_req && ($urandom % 64 == 0)) begin
                s_req = 1'b0;
            end
            if ($urandom % 25 == 0) script = ~script;
            tx_ready = md_grant ? ($urandom % 8 == 0) : ($urandom % 10 == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
